udp_pkt_feeder: RTL and testbench

UDP_PKT_FEEDER -- requirements
Module: udp_pkt_feeder

---
 rtl/udp_pkt_feeder_pkg.sv | 24 ++
 rtl/udp_pkt_feeder_if.sv | 30 +++
 rtl/udp_pkt_feeder_sync_fifo.sv | 50 +++++
 rtl/udp_pkt_feeder.sv | 120 ++++++++++++
 tb/tb_udp_pkt_feeder.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/udp_pkt_feeder_pkg.sv
// Shared types and length constants for the UDP packet feeder.
package udp_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    READY = 2'd1,
    SEND  = 2'd2
  } state_e;

  localparam int UDP_HDR_BYTES  = 8;
  localparam int IP_HDR_BYTES   = 20;
  localparam int BYTES_PER_WORD = 4;

  // UDP length field: payload plus the 8-byte UDP header.
  function automatic logic [15:0] udp_len(input int pkt_words);
    return 16'(pkt_words * BYTES_PER_WORD + UDP_HDR_BYTES);
  endfunction

  // IP total length: UDP length plus the 20-byte IP header.
  function automatic logic [15:0] ip_len(input int pkt_words);
    return 16'(pkt_words * BYTES_PER_WORD + UDP_HDR_BYTES + IP_HDR_BYTES);
  endfunction

endpackage

// File: rtl/udp_pkt_feeder_if.sv
// Sample-side and sender-side signals of the packet feeder.
interface udp_pkt_feeder_if;
  logic        capture_en;
  logic        cic_valid;
  logic [15:0] ch_a;
  logic [15:0] ch_b;
  logic        oen;
  logic        rdreq;
  logic [31:0] ram_rd_data;
  logic [15:0] tx_data_length;
  logic [15:0] tx_total_length;
  logic [15:0] pkt_count;
  logic        overflow;
  logic        underflow;
  logic [15:0] drop_count;

  // Driver of samples and read strobes (ADC path plus IP sender).
  modport master (
    output capture_en, cic_valid, ch_a, ch_b, rdreq,
    input  oen, ram_rd_data, tx_data_length, tx_total_length,
           pkt_count, overflow, underflow, drop_count
  );

  // The feeder itself.
  modport slave (
    input  capture_en, cic_valid, ch_a, ch_b, rdreq,
    output oen, ram_rd_data, tx_data_length, tx_total_length,
           pkt_count, overflow, underflow, drop_count
  );
endinterface

// File: rtl/udp_pkt_feeder_sync_fifo.sv
// Single-clock FIFO with registered read data and a level output.
module sync_fifo #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [AW:0]      level_o,
  output logic             full_o
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] rd_data_q;

  // Pointers carry an extra wrap bit so full and empty differ.
  assign level_o   = wr_ptr_q - rd_ptr_q;
  assign full_o    = (level_o == FULL_LVL);
  assign rd_data_o = rd_data_q;

  // Pointer advance; reset throws away everything buffered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage array, no reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  // Registered read port; holds its value between reads.
  always_ff @(posedge clk_i) begin
    if (rst_i)        rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem[rd_ptr_q[AW-1:0]];
  end

endmodule

// File: rtl/udp_pkt_feeder.sv
// Packs CIC sample pairs into a FIFO and releases them in fixed-size packets.
module udp_pkt_feeder
  import udp_pkg::*;
#(
  parameter int PKT_WORDS  = 256,
  parameter int FIFO_DEPTH = 512
) (
  input  logic           e_rxc,
  input  logic           reset,
  udp_pkt_feeder_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(PKT_WORDS + 1);
  localparam logic [AW:0]   PKT_LVL  = (AW+1)'(PKT_WORDS);
  localparam logic [CW-1:0] PKT_CNT  = CW'(PKT_WORDS);
  localparam logic [CW-1:0] LAST_IDX = CW'(PKT_WORDS - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic          pkt_done;
  logic [15:0]   pkt_count_q, drop_count_q;
  logic          overflow_q, underflow_q;

  logic          wr_try, wr_en, drop, rd_ok;
  logic [AW:0]   fifo_level;
  logic          fifo_full;

  // Full is judged on the level before this cycle's read.
  assign wr_try = bus.cic_valid && bus.capture_en;
  assign wr_en  = wr_try && !fifo_full;
  assign drop   = wr_try && fifo_full;
  assign rd_ok  = bus.rdreq &&
                  ((state_q == READY) || ((state_q == SEND) && (word_cnt_q < PKT_CNT)));

  sync_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(32)
  ) u_fifo (
    .clk_i    (e_rxc),
    .rst_i    (reset),
    .wr_en_i  (wr_en),
    .wr_data_i({bus.ch_a, bus.ch_b}),
    .rd_en_i  (rd_ok),
    .rd_data_o(bus.ram_rd_data),
    .level_o  (fifo_level),
    .full_o   (fifo_full)
  );

  // State register and per-packet read counter.
  always_ff @(posedge e_rxc) begin
    if (reset) begin
      state_q    <= FILL;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // Next-state: wait for a full packet, then count its words out.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    pkt_done   = 1'b0;
    case (state_q)
      FILL: begin
        word_cnt_d = '0;
        if (fifo_level >= PKT_LVL) state_d = READY;
      end
      READY: begin
        if (rd_ok) begin
          state_d    = SEND;
          word_cnt_d = CW'(1);
        end
      end
      SEND: begin
        if (rd_ok) begin
          if (word_cnt_q == LAST_IDX) begin
            state_d    = FILL;
            word_cnt_d = '0;
            pkt_done   = 1'b1;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d    = FILL;
        word_cnt_d = '0;
      end
    endcase
  end

  // Packet/drop counters and sticky error flags.
  always_ff @(posedge e_rxc) begin
    if (reset) begin
      pkt_count_q  <= '0;
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      if (pkt_done) pkt_count_q <= pkt_count_q + 1'b1;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 1'b1;
      end
      if (bus.rdreq && !rd_ok) underflow_q <= 1'b1;
    end
  end

  assign bus.oen             = (state_q == READY);
  assign bus.pkt_count       = pkt_count_q;
  assign bus.drop_count      = drop_count_q;
  assign bus.overflow        = overflow_q;
  assign bus.underflow       = underflow_q;
  assign bus.tx_data_length  = udp_len(PKT_WORDS);
  assign bus.tx_total_length = ip_len(PKT_WORDS);

endmodule

// File: tb/tb_udp_pkt_feeder.sv
// Directed scoreboard bench for udp_pkt_feeder.
module tb_udp_pkt_feeder;

  logic e_rxc = 1'b0;
  logic reset = 1'b1;

  always #5 e_rxc = ~e_rxc;

  udp_pkt_feeder_if bus_if ();

  udp_pkt_feeder #(
    .PKT_WORDS (256),
    .FIFO_DEPTH(512)
  ) dut (
    .e_rxc(e_rxc),
    .reset(reset),
    .bus  (bus_if)
  );

  logic [31:0] model_q [$];
  logic [31:0] exp_q   [$];
  logic [31:0] last_rd;
  logic [31:0] mon_exp;
  logic [15:0] seq;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) begin
      n_pass++;
      $display("check %s ok: 0x%08h", name, act);
    end else begin
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // One stimulus cycle; expected read results go to the scoreboard.
  task automatic cycle(input bit v, input bit en, input bit rd, input bit rd_ok);
    logic [31:0] w;
    bit          full;
    @(negedge e_rxc);
    w = {seq, seq ^ 16'h8000};
    bus_if.cic_valid  = v;
    bus_if.capture_en = en;
    bus_if.ch_a       = seq;
    bus_if.ch_b       = seq ^ 16'h8000;
    bus_if.rdreq      = rd;
    full = (model_q.size() >= 512);
    if (rd) begin
      if (rd_ok) last_rd = model_q.pop_front();
      exp_q.push_back(last_rd);
    end
    if (v && en && !full) model_q.push_back(w);
    if (v) seq++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge e_rxc);
    reset             = 1'b1;
    bus_if.cic_valid  = 1'b0;
    bus_if.capture_en = 1'b0;
    bus_if.rdreq      = 1'b0;
    @(negedge e_rxc);
    reset = 1'b0;
    model_q.delete();
    last_rd = '0;
  endtask

  // Monitor: every rdreq edge yields one ram_rd_data result to score.
  always @(posedge e_rxc) begin
    if (!reset && bus_if.rdreq) begin
      #1;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL rd_data: got 0x%08h, required no pending read", bus_if.ram_rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus_if.ram_rd_data === mon_exp) begin
          n_pass++;
          $display("rd_data 0x%08h ok", bus_if.ram_rd_data);
        end else begin
          $display("FAIL rd_data: got 0x%08h, required 0x%08h", bus_if.ram_rd_data, mon_exp);
        end
      end
    end
  end

  initial begin
    bus_if.cic_valid  = 1'b0;
    bus_if.capture_en = 1'b0;
    bus_if.ch_a       = '0;
    bus_if.ch_b       = '0;
    bus_if.rdreq      = 1'b0;
    seq     = 16'd1;
    last_rd = '0;
    repeat (3) @(negedge e_rxc);
    reset = 1'b0;

    // Reset state and constant lengths
    check("rst_oen", 32'(bus_if.oen), 32'd0);
    check("rst_pkt_count", 32'(bus_if.pkt_count), 32'd0);
    check("rst_drop_count", 32'(bus_if.drop_count), 32'd0);
    check("rst_overflow", 32'(bus_if.overflow), 32'd0);
    check("rst_underflow", 32'(bus_if.underflow), 32'd0);
    check("rst_rd_data", bus_if.ram_rd_data, 32'd0);
    check("tx_data_length", 32'(bus_if.tx_data_length), 32'd1032);
    check("tx_total_length", 32'(bus_if.tx_total_length), 32'd1052);

    // Basic packet
    repeat (256) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    check("oen_before_ready", 32'(bus_if.oen), 32'd0);
    idle(1);
    check("oen_ready", 32'(bus_if.oen), 32'd1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge e_rxc);
    #1;
    check("oen_after_first_rd", 32'(bus_if.oen), 32'd0);
    check("first_word", bus_if.ram_rd_data, 32'h0001_8001);
    repeat (255) cycle(1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);
    check("pkt_count_1", 32'(bus_if.pkt_count), 32'd1);
    check("oen_after_pkt", 32'(bus_if.oen), 32'd0);
    check("underflow_clean", 32'(bus_if.underflow), 32'd0);

    // Read before ready
    repeat (100) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    check("oen_partial", 32'(bus_if.oen), 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    check("underflow_set", 32'(bus_if.underflow), 32'd1);
    check("rd_data_held", bus_if.ram_rd_data, 32'h0100_8100);

    // Mid-packet reset
    repeat (156) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    check("oen_pkt2", 32'(bus_if.oen), 32'd1);
    repeat (100) cycle(1'b0, 1'b0, 1'b1, 1'b1);
    do_reset();
    check("mrst_oen", 32'(bus_if.oen), 32'd0);
    check("mrst_pkt_count", 32'(bus_if.pkt_count), 32'd0);
    check("mrst_underflow", 32'(bus_if.underflow), 32'd0);
    check("mrst_rd_data", bus_if.ram_rd_data, 32'd0);
    check("mrst_tx_data_length", 32'(bus_if.tx_data_length), 32'd1032);

    // Capture gating
    repeat (300) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("gate_oen", 32'(bus_if.oen), 32'd0);
    check("gate_drop_count", 32'(bus_if.drop_count), 32'd0);
    check("gate_overflow", 32'(bus_if.overflow), 32'd0);
    repeat (255) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    check("gate_level_255", 32'(bus_if.oen), 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    check("gate_oen_256", 32'(bus_if.oen), 32'd1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge e_rxc);
    #1;
    check("post_rst_first_word", bus_if.ram_rd_data, 32'h032D_832D);
    repeat (255) cycle(1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);
    check("post_rst_pkt_count", 32'(bus_if.pkt_count), 32'd1);

    // Simultaneous traffic and back-to-back packets
    repeat (256) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    check("sim_oen", 32'(bus_if.oen), 32'd1);
    repeat (256) cycle(1'b1, 1'b1, 1'b1, 1'b1);
    idle(1);
    check("sim_fill_gap", 32'(bus_if.oen), 32'd0);
    check("sim_pkt_count", 32'(bus_if.pkt_count), 32'd2);
    idle(1);
    check("sim_back_to_back", 32'(bus_if.oen), 32'd1);
    repeat (256) cycle(1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);
    check("sim_pkt_count_3", 32'(bus_if.pkt_count), 32'd3);
    check("sim_no_drop", 32'(bus_if.drop_count), 32'd0);

    // Overflow
    do_reset();
    repeat (520) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    check("ovf_flag", 32'(bus_if.overflow), 32'd1);
    check("ovf_drop_count", 32'(bus_if.drop_count), 32'd8);
    check("ovf_underflow", 32'(bus_if.underflow), 32'd0);
    idle(1);
    check("ovf_oen", 32'(bus_if.oen), 32'd1);
    repeat (256) cycle(1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);
    check("ovf_second_ready", 32'(bus_if.oen), 32'd1);
    repeat (256) cycle(1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);
    check("ovf_pkt_count", 32'(bus_if.pkt_count), 32'd2);
    check("ovf_oen_empty", 32'(bus_if.oen), 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    check("ovf_underflow_fill", 32'(bus_if.underflow), 32'd1);
    check("ovf_flag_sticky", 32'(bus_if.overflow), 32'd1);

    idle(2);
    check("pending_reads", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
